flash_sample_sequencer: RTL and testbench
=========================================

# flash_sample_sequencer

Sequences audio playback out of flash by driving the single-word flash read controller. Keeps a two-word prefetch buffer full by issuing read requests to the controller. Walks a word address range forward or backward with wrap-around. Hands one 16-bit sample per `sample_tick` to the audio output path. Sits between the playback control logic (keyboard/FSM, sample-rate divider) and the flash read controller.

## Interface
- `START_ADDR`, default 23'h000000: first word address of the audio region.
- `END_ADDR`, default 23'h07FFFF: last word address of the audio region, inclusive; must be ≥ `START_ADDR`.
- `clk` in 1: system clock; all logic on its rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `play` in 1: level; 1 = fetch and output samples, 0 = pause (buffers and address retained).
- `dir` in 1: 0 = forward, 1 = backward.
- `restart` in 1: one-cycle pulse; flush buffers and reload the start address for the current `dir`.
- `sample_tick` in 1: one-cycle pulse at the audio sample rate.
- `sample` out 16: current sample; held between ticks.
- `sample_valid` out 1: one-cycle pulse when `sample` is updated.
- `rd_req` out 1: to the controller `read` input.
- `rd_addr` out 23: to the controller `MEM_ADDR`; stable while `rd_req` = 1 and until `rd_busy` falls.
- `rd_busy` in 1: controller `busy`.
- `rd_data` in 32: controller `DATA`.
- `rd_error` in 1: controller `error`.
- `error` out 1: sticky fault flag.
- `underrun_cnt` out 8: saturating underrun count (see Configuration).

## Operation
- Reset values: `sample`=0, `sample_valid`=0, `rd_req`=0, `rd_addr`=`START_ADDR`, `error`=0, `underrun_cnt`=0. The next-fetch address is `START_ADDR`, both buffer slots are empty, the half index is 0, and the FSM is in S_IDLE.
- Buffer: `cur` word plus half index, and `nxt` word; each slot has a valid bit.
- FSM states and transitions:
  - S_IDLE → S_REQ when `play`=1, `error`=0, `restart`=0 and `nxt` is not valid. On entry, drive `rd_addr` with the next-fetch address and set `rd_req`=1.
  - S_REQ: hold `rd_req`=1 until `rd_busy`=1, then drop `rd_req` → S_WAIT.
  - S_WAIT: when `rd_busy`=0, capture `rd_data`. Store it in `cur` if `cur` is empty after this cycle's tick, otherwise in `nxt`. Advance the next-fetch address → S_IDLE.
  - Any state → S_ERR when `rd_error`=1. S_ERR sets `error`=1 and `rd_req`=0, and is left only by reset.
- Address advance:
  - Forward: +1; `END_ADDR` wraps to `START_ADDR`.
  - Backward: −1; `START_ADDR` wraps to `END_ADDR`.
  - `dir` is sampled at each advance; words already buffered are still played.
- Half order:
  - Forward: `[15:0]` then `[31:16]`.
  - Backward: `[31:16]` then `[15:0]`.
  - Order is fixed per word at capture time.
- Tick with `play`=1 and `cur` valid:
  - `sample` ← selected half and `sample_valid` pulses.
  - After the second half: `cur` ← `nxt` (validity included), `nxt` becomes empty, half index ← 0.
- Tick with `play`=1 and `cur` empty: underrun. `sample` holds, no `sample_valid` pulse, and `underrun_cnt` increments, saturating at 255.
- Tick with `play`=0: ignored.
- `restart`:
  - Empties both slots and sets half index to 0.
  - Next-fetch address ← `START_ADDR` (`dir`=0) or `END_ADDR` (`dir`=1).
  - A fetch in flight completes its handshake but its word is discarded.
  - `restart` and a tick in the same cycle: the tick counts as an underrun.
- Error: after `error`=1, ticks still drain buffered samples; no new fetches are issued.

## Timing
- `rd_req` rises 1 cycle after the S_IDLE launch condition is met.
- The capture cycle is the first cycle with `rd_busy`=0 in S_WAIT. The data is usable as `cur` on the next tick.
- `sample`/`sample_valid` update the cycle after `sample_tick`, giving 1-cycle tick latency.
- A fetch and a tick in the same cycle are both honoured: the tick moves `nxt`→`cur` first, then the fetched word fills the empty slot.
- `sample_tick` spacing is at least 4 cycles. Ticks closer than one fetch time may underrun.
- `RST_N` low mid-handshake: all state returns to reset values immediately, and `rd_req` drops asynchronously.

## Configuration
- `FLASH_SEQ_UNDERRUN_CNT_EN` defined: the 8-bit saturating `underrun_cnt` counter is built as described.
- Not defined: no counter is built and `underrun_cnt` is constant 0. Underruns still suppress `sample_valid` and hold `sample`.

## Test plan
- Reset, then `play`=1, `dir`=0, with the flash model holding word `START_ADDR`=32'hBBBB_AAAA and the next word 32'hDDDD_CCCC. Four ticks → `sample` = 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, each with a `sample_valid` pulse. `rd_addr` sequence is 0, 1, 2, …
- `START_ADDR`=10, `END_ADDR`=12, forward: observed fetch addresses are 10, 11, 12, 10, 11. With `dir`=1 after `restart`: 12, 11, 10, 12, with the halves played high first.
- `play`=1 with a tick every 4 cycles and a flash model latency of 30 cycles: `underrun_cnt` increments with no `sample_valid` on those ticks, and saturates at 255. With the macro undefined, `underrun_cnt` stays 0.
- `restart` pulse while in S_WAIT: the in-flight word is discarded. The next fetch is at `START_ADDR`, and the first sample after restart is the low half of word `START_ADDR`.
- Model raises `rd_error` during S_WAIT: `error`=1 next cycle and `rd_req` stays 0 forever. Buffered samples still drain on ticks, then underruns follow.
- `RST_N` pulsed low while `rd_req`=1: `rd_req`, `sample`, `error` and `underrun_cnt` are 0 immediately. Playback resumes from `START_ADDR` after release.

Source files
------------

// File: rtl/flash_sample_sequencer_if.sv
// Read-request channel between the sample sequencer and the single-word
// flash read controller.
interface flash_sample_sequencer_if;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic        rd_error;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_busy,
        input  rd_data,
        input  rd_error
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_busy,
        output rd_data,
        output rd_error
    );
endinterface

// File: rtl/flash_sample_sequencer.sv
// Audio sample sequencer: keeps a two-word prefetch buffer filled from flash and
// hands out one 16-bit half-word per sample tick. Optional FLASH_SEQ_UNDERRUN_CNT_EN
// builds the saturating underrun counter; otherwise underrun_cnt_o is tied to 0.
//
// state  | meaning
// S_IDLE | no fetch in flight; launches one when nxt slot is free
// S_REQ  | rd_req held high until the controller reports busy
// S_WAIT | waiting for busy to fall, then captures rd_data
// S_ERR  | controller fault seen; no more fetches until reset
module flash_sample_sequencer #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_i,
    input  logic        dir_i,
    input  logic        restart_i,
    input  logic        sample_tick_i,
    output logic [15:0] sample_o,
    output logic        sample_valid_o,
    output logic        error_o,
    output logic [7:0]  underrun_cnt_o,
    flash_sample_sequencer_if.master rd_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rd_req_q, rd_req_d;
    logic [22:0] rd_addr_q, rd_addr_d;
    logic [22:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] cur_q, cur_d;
    logic        cur_hi_q, cur_hi_d;
    logic        cur_vld_q, cur_vld_d;
    logic        half_q, half_d;
    logic [31:0] nxt_q, nxt_d;
    logic        nxt_hi_q, nxt_hi_d;
    logic        nxt_vld_q, nxt_vld_d;
    logic [15:0] sample_q, sample_d;
    logic        sample_valid_q, sample_valid_d;
    logic        error_q, error_d;
    logic        discard_q, discard_d;
    logic        capture;
    logic        tick_play;

    function automatic logic [22:0] next_addr(input logic [22:0] addr, input logic back);
        logic [22:0] res;
        if (!back) begin
            res = (addr == END_ADDR) ? START_ADDR : addr + 23'd1;
        end else begin
            res = (addr == START_ADDR) ? END_ADDR : addr - 23'd1;
        end
        return res;
    endfunction

    assign tick_play = sample_tick_i & play_i;

    always_comb begin
        state_d        = state_q;
        rd_req_d       = rd_req_q;
        rd_addr_d      = rd_addr_q;
        fetch_addr_d   = fetch_addr_q;
        cur_d          = cur_q;
        cur_hi_d       = cur_hi_q;
        cur_vld_d      = cur_vld_q;
        half_d         = half_q;
        nxt_d          = nxt_q;
        nxt_hi_d       = nxt_hi_q;
        nxt_vld_d      = nxt_vld_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        error_d        = error_q;
        discard_d      = discard_q;
        capture        = 1'b0;

        // Tick is resolved before the fetch so a same-cycle capture sees the shifted buffer.
        if (tick_play && !restart_i && cur_vld_q) begin
            sample_d       = (half_q ^ cur_hi_q) ? cur_q[31:16] : cur_q[15:0];
            sample_valid_d = 1'b1;
            if (half_q) begin
                cur_d     = nxt_q;
                cur_hi_d  = nxt_hi_q;
                cur_vld_d = nxt_vld_q;
                nxt_vld_d = 1'b0;
                half_d    = 1'b0;
            end else begin
                half_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (play_i && !error_q && !restart_i && !nxt_vld_q) begin
                    state_d   = S_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = fetch_addr_q;
                end
            end
            S_REQ: begin
                if (restart_i) begin
                    discard_d = 1'b1;
                end
                if (rd_if.rd_busy) begin
                    rd_req_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!rd_if.rd_busy) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    capture   = !discard_q && !restart_i;
                end else if (restart_i) begin
                    discard_d = 1'b1;
                end
            end
            S_ERR: begin
                rd_req_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rd_if.rd_error) begin
            state_d  = S_ERR;
            rd_req_d = 1'b0;
            error_d  = 1'b1;
        end else if (capture) begin
            if (!cur_vld_d) begin
                cur_d     = rd_if.rd_data;
                cur_hi_d  = dir_i;
                cur_vld_d = 1'b1;
                half_d    = 1'b0;
            end else begin
                nxt_d     = rd_if.rd_data;
                nxt_hi_d  = dir_i;
                nxt_vld_d = 1'b1;
            end
            fetch_addr_d = next_addr(fetch_addr_q, dir_i);
        end

        if (restart_i) begin
            cur_vld_d    = 1'b0;
            nxt_vld_d    = 1'b0;
            half_d       = 1'b0;
            fetch_addr_d = dir_i ? END_ADDR : START_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= START_ADDR;
            fetch_addr_q   <= START_ADDR;
            cur_q          <= '0;
            cur_hi_q       <= 1'b0;
            cur_vld_q      <= 1'b0;
            half_q         <= 1'b0;
            nxt_q          <= '0;
            nxt_hi_q       <= 1'b0;
            nxt_vld_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            error_q        <= 1'b0;
            discard_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            fetch_addr_q   <= fetch_addr_d;
            cur_q          <= cur_d;
            cur_hi_q       <= cur_hi_d;
            cur_vld_q      <= cur_vld_d;
            half_q         <= half_d;
            nxt_q          <= nxt_d;
            nxt_hi_q       <= nxt_hi_d;
            nxt_vld_q      <= nxt_vld_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            error_q        <= error_d;
            discard_q      <= discard_d;
        end
    end

`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    logic       underrun;
    logic [7:0] underrun_cnt_q;

    // A restart in the tick cycle empties the buffer, so that tick is an underrun.
    assign underrun = tick_play & (restart_i | ~cur_vld_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_q <= '0;
        end else if (underrun && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 8'd1;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`else
    assign underrun_cnt_o = '0;
`endif

    assign rd_if.rd_req  = rd_req_q;
    assign rd_if.rd_addr = rd_addr_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Bench for flash_sample_sequencer: flash controller model plus a sample-queue
// reference model checked every cycle, with directed tables and random phases.
module tb_flash_sample_sequencer;
    localparam logic [22:0] START = 23'd10;
    localparam logic [22:0] ENDA  = 23'd12;
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    localparam int SAT = 255;
`else
    localparam int SAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play, dir, restart, tick;
    logic [15:0] sample;
    logic        sample_valid, error;
    logic [7:0]  urun;

    flash_sample_sequencer_if u_if();

    flash_sample_sequencer #(.START_ADDR(START), .END_ADDR(ENDA)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .play_i         (play),
        .dir_i          (dir),
        .restart_i      (restart),
        .sample_tick_i  (tick),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .error_o        (error),
        .underrun_cnt_o (urun),
        .rd_if          (u_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: pending samples in play order
    logic [15:0] mq[$];
    logic [22:0] m_fetch, m_laddr;
    bit          m_err, m_req, m_eng, m_wait, m_disc, m_valid;
    logic [15:0] m_sample;
    int          m_urun;

    logic [31:0] mem [16];
    bit          fl_busy_st, fl_err_inj;
    int          fl_cnt, fl_lat;
    logic [22:0] fl_addr;

    int          auto_gap, gap_cnt;
    bit          rnd_mode;
    logic [15:0] seen[$];

    typedef struct packed {
        logic        d;
        logic        r;
        logic [22:0] a;
    } fetch_vec_t;
    fetch_vec_t fv [9];
    logic [15:0] exp_first [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] adv(input logic [22:0] a, input bit back);
        if (!back) return (a == ENDA) ? START : a + 23'd1;
        return (a == START) ? ENDA : a - 23'd1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch = START; m_laddr = START;
        m_err = 0; m_req = 0; m_eng = 0; m_wait = 0; m_disc = 0; m_valid = 0;
        m_sample = '0; m_urun = 0;
        fl_busy_st = 0; fl_err_inj = 0; fl_cnt = 0;
        u_if.rd_busy = 1'b0; u_if.rd_error = 1'b0; u_if.rd_data = '0;
    endtask

    task automatic model_edge();
        int          size0;
        bit          busy_in, err_in;
        logic [31:0] w;
        size0   = mq.size();
        busy_in = u_if.rd_busy;
        err_in  = u_if.rd_error;
        m_valid = 0;
        if (tick && play) begin
            if (restart || mq.size() == 0) begin
                if (SAT != 0 && m_urun < SAT) m_urun++;
            end else begin
                m_sample = mq.pop_front();
                m_valid  = 1;
            end
        end
        if (err_in) begin
            m_err = 1; m_req = 0; m_eng = 0; m_wait = 0;
        end else if (m_eng) begin
            if (m_wait && !busy_in) begin
                if (!m_disc && !restart) begin
                    w = mem[m_laddr[3:0]];
                    if (dir) begin mq.push_back(w[31:16]); mq.push_back(w[15:0]); end
                    else     begin mq.push_back(w[15:0]);  mq.push_back(w[31:16]); end
                    m_fetch = adv(m_fetch, dir);
                end
                m_eng = 0; m_wait = 0; m_disc = 0;
            end else begin
                if (restart) m_disc = 1;
                if (m_req && busy_in) begin m_req = 0; m_wait = 1; end
            end
        end else if (play && !m_err && !restart && size0 <= 2) begin
            m_req = 1; m_eng = 1; m_laddr = m_fetch;
        end
        if (restart) begin
            mq.delete();
            m_fetch = dir ? ENDA : START;
        end
    endtask

    task automatic flash_after();
        u_if.rd_error = 1'b0;
        if (!fl_busy_st) begin
            if (u_if.rd_req === 1'b1) begin
                fl_busy_st = 1; fl_addr = u_if.rd_addr; fl_cnt = fl_lat;
                u_if.rd_busy = 1'b1; u_if.rd_data = $urandom;
            end
        end else begin
            u_if.rd_data = $urandom;
            if (fl_cnt > 0) fl_cnt--;
            else if (fl_err_inj) begin u_if.rd_error = 1'b1; fl_err_inj = 0; end
            else begin
                u_if.rd_busy = 1'b0; u_if.rd_data = mem[fl_addr[3:0]]; fl_busy_st = 0;
            end
        end
    endtask

    task automatic checks();
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
        chk("sample", {16'd0, sample}, {16'd0, m_sample});
        chk("rd_req", {31'd0, u_if.rd_req}, {31'd0, m_req});
        chk("error", {31'd0, error}, {31'd0, m_err});
        chk("underrun_cnt", {24'd0, urun}, m_urun);
        if (m_eng) chk("rd_addr", {9'd0, u_if.rd_addr}, {9'd0, m_laddr});
        if (sample_valid === 1'b1) seen.push_back(sample);
    endtask

    task automatic step();
        if (rnd_mode) begin
            if ($urandom_range(0, 199) == 0) begin restart = 1'b1; dir = 1'($urandom); end
            if ($urandom_range(0, 299) == 0) dir = ~dir;
            if ($urandom_range(0, 149) == 0) play = ~play;
            fl_lat = $urandom_range(0, 8);
        end
        if (auto_gap > 0) begin
            if (gap_cnt >= auto_gap) begin
                tick = 1'b1; gap_cnt = 0;
                if (rnd_mode) auto_gap = $urandom_range(4, 12);
            end else gap_cnt++;
        end
        @(posedge clk);
        model_edge();
        #1;
        checks();
        flash_after();
        tick = 1'b0;
        restart = 1'b0;
    endtask

    task automatic wait_rise(input int lim, output bit ok);
        logic p;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            p = u_if.rd_req;
            step();
            if (p === 1'b0 && u_if.rd_req === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_rd_req: no rd_req rise within %0d cycles", lim);
        end
    endtask

    task automatic wait_samples(input int n, input int lim);
        for (int i = 0; i < lim && seen.size() < n; i++) step();
        chk("sample_count", seen.size(), (seen.size() >= n) ? seen.size() : n);
    endtask

    task automatic check_reset_values();
        chk("rst_rd_req", {31'd0, u_if.rd_req}, 0);
        chk("rst_sample", {16'd0, sample}, 0);
        chk("rst_sample_valid", {31'd0, sample_valid}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_underrun", {24'd0, urun}, 0);
        chk("rst_rd_addr", {9'd0, u_if.rd_addr}, {9'd0, START});
    endtask

    initial begin
        bit ok, found;
        int reqs;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[10] = 32'hBBBB_AAAA;
        mem[11] = 32'hDDDD_CCCC;
        mem[12] = 32'hFFFF_EEEE;
        fv[0] = '{1'b0, 1'b0, 23'd10};
        fv[1] = '{1'b0, 1'b0, 23'd11};
        fv[2] = '{1'b0, 1'b0, 23'd12};
        fv[3] = '{1'b0, 1'b0, 23'd10};
        fv[4] = '{1'b0, 1'b0, 23'd11};
        fv[5] = '{1'b1, 1'b1, 23'd12};
        fv[6] = '{1'b1, 1'b0, 23'd11};
        fv[7] = '{1'b1, 1'b0, 23'd10};
        fv[8] = '{1'b1, 1'b0, 23'd12};
        exp_first[0] = 16'hAAAA; exp_first[1] = 16'hBBBB;
        exp_first[2] = 16'hCCCC; exp_first[3] = 16'hDDDD;

        play = 0; dir = 0; restart = 0; tick = 0;
        auto_gap = 0; gap_cnt = 0; rnd_mode = 0; fl_lat = 2;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check_reset_values();
        @(negedge clk) rst_n = 1'b1;

        // fetch-address table: forward wrap, then restart backward
        play = 1; auto_gap = 6;
        for (int i = 0; i < 9; i++) begin
            dir = fv[i].d;
            if (fv[i].r) begin
                restart = 1'b1;
                step();
                seen.delete();
            end
            wait_rise(300, ok);
            if (ok) chk($sformatf("fetch_addr[%0d]", i), {9'd0, u_if.rd_addr}, {9'd0, fv[i].a});
        end
        wait_samples(2, 300);
        if (seen.size() >= 2) begin
            chk("back_first_half", {16'd0, seen[0]}, 32'hFFFF);
            chk("back_second_half", {16'd0, seen[1]}, 32'hEEEE);
        end

        // restart while the fetch is in S_WAIT
        seen.delete();
        dir = 0; restart = 1'b1; step();
        dir = 0; restart = 1'b1; step();
        fl_lat = 20;
        wait_rise(300, ok);
        if (ok) chk("first_fetch_after_restart", {9'd0, u_if.rd_addr}, {9'd0, START});
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (u_if.rd_busy === 1'b1 && u_if.rd_req === 1'b0) begin found = 1; break; end
            step();
        end
        chk("reached_wait", {31'd0, found}, 1);
        restart = 1'b1; step();
        seen.delete();
        wait_rise(300, ok);
        if (ok) chk("refetch_start", {9'd0, u_if.rd_addr}, {9'd0, START});
        wait_samples(1, 300);
        if (seen.size() >= 1) chk("first_sample_after_restart", {16'd0, seen[0]}, 32'hAAAA);
        for (int i = 0; i < 4 && seen.size() < 4; i++) wait_samples(4, 200);

        // slow flash, fast ticks: underruns up to saturation
        fl_lat = 30; auto_gap = 3;
        for (int i = 0; i < 2000; i++) step();
        chk("underrun_saturated", {24'd0, urun}, SAT);

        // asynchronous reset in the middle of a handshake
        fl_lat = 3; auto_gap = 6;
        wait_rise(300, ok);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        wait_rise(300, ok);
        if (ok) chk("resume_addr", {9'd0, u_if.rd_addr}, {9'd0, START});

        // random play/dir/restart/tick/latency
        rnd_mode = 1; auto_gap = 5;
        for (int i = 0; i < 3000; i++) step();
        rnd_mode = 0; play = 1; dir = 0; auto_gap = 6; fl_lat = 10;

        // controller error: sticky flag, no more requests, buffer drains
        for (int i = 0; i < 60; i++) step();
        fl_err_inj = 1;
        for (int i = 0; i < 300 && error !== 1'b1; i++) step();
        chk("error_set", {31'd0, error}, 1);
        reqs = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (u_if.rd_req !== 1'b0) reqs++;
        end
        chk("no_req_after_error", reqs, 0);
        chk("queue_drained", mq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
